// File: rtl/pipe_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_hazard_scoreboard
//
// Tracks the destination register of every instruction in flight after decode
// (stage 0 = EX ... DEPTH-1 = WB). From that record it chooses the forwarding
// source for both decode operands and raises a load-use stall when the
// youngest producer of an operand is a load whose data is not yet on
// stage_data. It also keeps a saturating count of stall cycles.
//
// Ports
//   clock, resetn           clock (rising edge) and async active-low reset
//   id_valid                decode holds a real instruction
//   id_rs, id_rt            source register addresses
//   id_uses_rs, id_uses_rt  source operand is actually read
//   id_wreg, id_m2reg       instruction writes a register / is a load
//   id_dest                 destination register
//   flush                   kill the decode instruction this cycle
//   qa, qb                  register-file read data
//   stage_data              per-stage result, slice k belongs to stage k
//   stall                   hold PC and the IF/ID register
//   fwda, fwdb              operand source: 0 = register file, k+1 = stage k
//   dfwdA, dfwdB            selected operand data
//   stage_valid/wreg/m2reg  tracked per-stage flags
//   stage_dest              tracked per-stage destinations
//   stall_cnt               saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rs,
  input  logic [REG_AW-1:0]         id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_wreg,
  input  logic                      id_m2reg,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         qa,
  input  logic [DATA_W-1:0]         qb,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  output logic                      stall,
  output logic [SEL_W-1:0]          fwda,
  output logic [SEL_W-1:0]          fwdb,
  output logic [DATA_W-1:0]         dfwdA,
  output logic [DATA_W-1:0]         dfwdB,
  output logic [DEPTH-1:0]          stage_valid,
  output logic [DEPTH-1:0]          stage_wreg,
  output logic [DEPTH-1:0]          stage_m2reg,
  output logic [DEPTH*REG_AW-1:0]   stage_dest,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [DEPTH-1:0]             stageValid_q;
  logic [DEPTH-1:0]             stageWreg_q;
  logic [DEPTH-1:0]             stageM2reg_q;
  logic [DEPTH-1:0][REG_AW-1:0] stageDest_q;
  logic [CNT_W-1:0]             stallCnt_q;
  logic [CNT_W-1:0]             stallCnt_d;

  logic                         stage0Valid_d;
  logic                         stage0Wreg_d;
  logic                         stage0M2reg_d;
  logic [REG_AW-1:0]            stage0Dest_d;

  logic                         hazA;
  logic                         hazB;
  logic                         loadDecode;

  // Hazard detection. Stages are scanned oldest to youngest so that a match
  // in a younger stage overwrites any older one: the youngest producer wins.
  // Requiring a non-zero destination is what keeps $0 out of forwarding and
  // stalling, since a zero source can then never match.
  always_comb begin
    fwda = '0;
    fwdb = '0;
    hazA = 1'b0;
    hazB = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stageValid_q[k] && stageWreg_q[k] && (stageDest_q[k] != '0)) begin
        if (id_uses_rs && (stageDest_q[k] == id_rs)) begin
          fwda = SEL_W'(k + 1);
          hazA = stageM2reg_q[k] && (k < LOAD_AVAIL);
        end
        if (id_uses_rt && (stageDest_q[k] == id_rt)) begin
          fwdb = SEL_W'(k + 1);
          hazB = stageM2reg_q[k] && (k < LOAD_AVAIL);
        end
      end
    end
  end

  // A flush kills the decode instruction, so it can never be stalled.
  assign stall = id_valid && !flush && (hazA || hazB);

  // Operand data mux: register file by default, otherwise the chosen stage.
  always_comb begin
    dfwdA = qa;
    dfwdB = qb;
    for (int k = 0; k < DEPTH; k++) begin
      if (fwda == SEL_W'(k + 1)) begin
        dfwdA = stage_data[k*DATA_W +: DATA_W];
      end
      if (fwdb == SEL_W'(k + 1)) begin
        dfwdB = stage_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Stage 0 takes the decode instruction only when it really moves forward;
  // stalls and flushes both inject an all-zero bubble.
  always_comb begin
    loadDecode    = id_valid && !stall && !flush;
    stage0Valid_d = loadDecode;
    stage0Wreg_d  = loadDecode && id_wreg;
    stage0M2reg_d = loadDecode && id_m2reg;
    stage0Dest_d  = loadDecode ? id_dest : '0;
    stallCnt_d    = stallCnt_q;
    if (stall && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  // Stage tracking shift register and stall counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stageValid_q <= '0;
      stageWreg_q  <= '0;
      stageM2reg_q <= '0;
      stageDest_q  <= '0;
      stallCnt_q   <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        stageValid_q[k] <= stageValid_q[k-1];
        stageWreg_q[k]  <= stageWreg_q[k-1];
        stageM2reg_q[k] <= stageM2reg_q[k-1];
        stageDest_q[k]  <= stageDest_q[k-1];
      end
      stageValid_q[0] <= stage0Valid_d;
      stageWreg_q[0]  <= stage0Wreg_d;
      stageM2reg_q[0] <= stage0M2reg_d;
      stageDest_q[0]  <= stage0Dest_d;
      stallCnt_q      <= stallCnt_d;
    end
  end

  assign stage_valid = stageValid_q;
  assign stage_wreg  = stageWreg_q;
  assign stage_m2reg = stageM2reg_q;
  assign stage_dest  = stageDest_q;
  assign stall_cnt   = stallCnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_scoreboard
//
// Drives one shared instruction stream into three configurations of the
// scoreboard: defaults (cfg 0), CNT_W=2 (cfg 1) and DEPTH=4/LOAD_AVAIL=2
// (cfg 2). An instruction-level reference model predicts every cycle's
// outputs into a queue; a monitor on the falling edge pops and compares.
// Directed scenarios add a few hand-derived checks on top.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic [4:0] dest;
  } entry_t;

  typedef struct packed {
    logic [1:0]  cfg;
    logic        chkFwd;
    logic        stall;
    logic [2:0]  fwda;
    logic [2:0]  fwdb;
    logic [31:0] dA;
    logic [31:0] dB;
    logic [15:0] cnt;
    logic [3:0]  sv;
  } expect_t;

  logic         clock = 1'b0;
  logic         resetn;
  logic         idValid;
  logic [4:0]   idRs;
  logic [4:0]   idRt;
  logic         idUsesRs;
  logic         idUsesRt;
  logic         idWreg;
  logic         idM2reg;
  logic [4:0]   idDest;
  logic         flush;
  logic [31:0]  qa;
  logic [31:0]  qb;
  logic [127:0] stageData;

  logic         stall0, stall1, stall2;
  logic [1:0]   fwda0, fwdb0, fwda1, fwdb1;
  logic [2:0]   fwda2, fwdb2;
  logic [31:0]  dA0, dB0, dA1, dB1, dA2, dB2;
  logic [2:0]   sv0, sw0, sm0, sv1, sw1, sm1;
  logic [3:0]   sv2, sw2, sm2;
  logic [14:0]  sd0, sd1;
  logic [19:0]  sd2;
  logic [15:0]  cnt0, cnt2;
  logic [1:0]   cnt1;

  int checkCount = 0;
  int errorCount = 0;

  entry_t  mPipe [3][4];
  int      mCnt [3];
  expect_t expQ [$];

  always #5 clock = ~clock;

  pipe_hazard_scoreboard dut0 (
    .clock(clock), .resetn(resetn), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_wreg(idWreg), .id_m2reg(idM2reg),
    .id_dest(idDest), .flush(flush), .qa(qa), .qb(qb), .stage_data(stageData[95:0]),
    .stall(stall0), .fwda(fwda0), .fwdb(fwdb0), .dfwdA(dA0), .dfwdB(dB0),
    .stage_valid(sv0), .stage_wreg(sw0), .stage_m2reg(sm0), .stage_dest(sd0),
    .stall_cnt(cnt0)
  );

  pipe_hazard_scoreboard #(.CNT_W(2)) dut1 (
    .clock(clock), .resetn(resetn), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_wreg(idWreg), .id_m2reg(idM2reg),
    .id_dest(idDest), .flush(flush), .qa(qa), .qb(qb), .stage_data(stageData[95:0]),
    .stall(stall1), .fwda(fwda1), .fwdb(fwdb1), .dfwdA(dA1), .dfwdB(dB1),
    .stage_valid(sv1), .stage_wreg(sw1), .stage_m2reg(sm1), .stage_dest(sd1),
    .stall_cnt(cnt1)
  );

  pipe_hazard_scoreboard #(.DEPTH(4), .LOAD_AVAIL(2)) dut2 (
    .clock(clock), .resetn(resetn), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_wreg(idWreg), .id_m2reg(idM2reg),
    .id_dest(idDest), .flush(flush), .qa(qa), .qb(qb), .stage_data(stageData),
    .stall(stall2), .fwda(fwda2), .fwdb(fwdb2), .dfwdA(dA2), .dfwdB(dB2),
    .stage_valid(sv2), .stage_wreg(sw2), .stage_m2reg(sm2), .stage_dest(sd2),
    .stall_cnt(cnt2)
  );

  function automatic int cfgDepth(int c);
    return (c == 2) ? 4 : 3;
  endfunction

  function automatic int cfgLoadAvail(int c);
    return (c == 2) ? 2 : 1;
  endfunction

  function automatic int cfgCntMax(int c);
    return (c == 1) ? 3 : 65535;
  endfunction

  // Index of the youngest in-flight writer of register r, or -1.
  function automatic int youngest(int c, logic [4:0] r, logic uses);
    if (!uses || (r == 5'd0)) return -1;
    for (int k = 0; k < cfgDepth(c); k++) begin
      if (mPipe[c][k].valid && mPipe[c][k].wreg && (mPipe[c][k].dest == r)) return k;
    end
    return -1;
  endfunction

  // A load whose value is not yet available is the youngest producer.
  function automatic logic modelStall(int c);
    int a;
    int b;
    logic s;
    s = 1'b0;
    a = youngest(c, idRs, idUsesRs);
    b = youngest(c, idRt, idUsesRt);
    if (idValid && !flush) begin
      if (a >= 0) begin
        if (mPipe[c][a].m2reg && (a < cfgLoadAvail(c))) s = 1'b1;
      end
      if (b >= 0) begin
        if (mPipe[c][b].m2reg && (b < cfgLoadAvail(c))) s = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      mCnt[c] = 0;
      for (int k = 0; k < 4; k++) mPipe[c][k] = '0;
    end
  endtask

  // Clock-edge behaviour: every instruction moves one stage older and the
  // decode instruction enters unless it was stalled or flushed.
  task automatic modelAdvance();
    logic s;
    if (!resetn) begin
      modelReset();
    end else begin
      for (int c = 0; c < 3; c++) begin
        s = modelStall(c);
        if (s && (mCnt[c] < cfgCntMax(c))) mCnt[c] = mCnt[c] + 1;
        for (int k = cfgDepth(c) - 1; k >= 1; k--) mPipe[c][k] = mPipe[c][k-1];
        if (idValid && !s && !flush) mPipe[c][0] = '{1'b1, idWreg, idM2reg, idDest};
        else mPipe[c][0] = '0;
      end
    end
  endtask

  task automatic pushExpect();
    expect_t e;
    int a;
    int b;
    for (int c = 0; c < 3; c++) begin
      e = '0;
      a = youngest(c, idRs, idUsesRs);
      b = youngest(c, idRt, idUsesRt);
      e.cfg    = 2'(c);
      e.stall  = modelStall(c);
      e.chkFwd = !e.stall;
      e.fwda   = (a >= 0) ? 3'(a + 1) : 3'd0;
      e.fwdb   = (b >= 0) ? 3'(b + 1) : 3'd0;
      e.dA     = (a >= 0) ? stageData[a*32 +: 32] : qa;
      e.dB     = (b >= 0) ? stageData[b*32 +: 32] : qb;
      e.cnt    = 16'(mCnt[c]);
      for (int k = 0; k < cfgDepth(c); k++) e.sv[k] = mPipe[c][k].valid;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One decode cycle: step the model across the edge, drive new inputs just
  // after it and queue the predicted outputs for this cycle.
  task automatic applyStimulus(input logic rstn, input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic ur, input logic ut,
                               input logic w, input logic m, input logic [4:0] d,
                               input logic fl);
    @(posedge clock);
    modelAdvance();
    #1;
    resetn    = rstn;
    idValid   = v;
    idRs      = rs;
    idRt      = rt;
    idUsesRs  = ur;
    idUsesRt  = ut;
    idWreg    = w;
    idM2reg   = m;
    idDest    = d;
    flush     = fl;
    qa        = $urandom;
    qb        = $urandom;
    stageData = {$urandom, $urandom, $urandom, $urandom};
    if (!resetn) modelReset();
    pushExpect();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: compares every queued prediction against the matching DUT.
  always @(negedge clock) begin
    expect_t e;
    logic        aStall;
    logic [2:0]  aFwda, aFwdb;
    logic [31:0] aDA, aDB;
    logic [15:0] aCnt;
    logic [3:0]  aSv;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      case (e.cfg)
        2'd0: begin
          aStall = stall0; aFwda = {1'b0, fwda0}; aFwdb = {1'b0, fwdb0};
          aDA = dA0; aDB = dB0; aCnt = cnt0; aSv = {1'b0, sv0};
        end
        2'd1: begin
          aStall = stall1; aFwda = {1'b0, fwda1}; aFwdb = {1'b0, fwdb1};
          aDA = dA1; aDB = dB1; aCnt = {14'd0, cnt1}; aSv = {1'b0, sv1};
        end
        default: begin
          aStall = stall2; aFwda = fwda2; aFwdb = fwdb2;
          aDA = dA2; aDB = dB2; aCnt = cnt2; aSv = sv2;
        end
      endcase
      checkOutput($sformatf("cfg%0d stall", e.cfg), 32'(aStall), 32'(e.stall));
      checkOutput($sformatf("cfg%0d stall_cnt", e.cfg), 32'(aCnt), 32'(e.cnt));
      checkOutput($sformatf("cfg%0d stage_valid", e.cfg), 32'(aSv), 32'(e.sv));
      if (e.chkFwd) begin
        checkOutput($sformatf("cfg%0d fwda", e.cfg), 32'(aFwda), 32'(e.fwda));
        checkOutput($sformatf("cfg%0d fwdb", e.cfg), 32'(aFwdb), 32'(e.fwdb));
        checkOutput($sformatf("cfg%0d dfwdA", e.cfg), aDA, e.dA);
        checkOutput($sformatf("cfg%0d dfwdB", e.cfg), aDB, e.dB);
      end
    end
  end

  initial begin
    resetn = 1'b0; idValid = 1'b0; idRs = '0; idRt = '0; idUsesRs = 1'b0;
    idUsesRt = 1'b0; idWreg = 1'b0; idM2reg = 1'b0; idDest = '0; flush = 1'b0;
    qa = '0; qb = '0; stageData = '0;
    modelReset();

    // Reset values
    doReset();
    #3;
    checkOutput("reset stall", 32'(stall0), 32'd0);
    checkOutput("reset stage_valid", 32'(sv0), 32'd0);
    checkOutput("reset stall_cnt", 32'(cnt0), 32'd0);
    checkOutput("reset dfwdA", dA0, qa);

    // ALU write $3 then read $3
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    checkOutput("alu fwda", 32'(fwda0), 32'd1);
    checkOutput("alu dfwdA", dA0, stageData[31:0]);
    checkOutput("alu stall", 32'(stall0), 32'd0);

    // Two producers of $3: youngest wins, then one instruction in between
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    checkOutput("youngest fwda", 32'(fwda0), 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    checkOutput("gap fwda", 32'(fwda0), 32'd2);

    // Load $5 then read $5 as rt: one stall (default), two stalls (deep)
    doReset();
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    checkOutput("load-use stall", 32'(stall0), 32'd1);
    checkOutput("deep load-use stall 1", 32'(stall2), 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    checkOutput("after stall", 32'(stall0), 32'd0);
    checkOutput("after stall fwdb", 32'(fwdb0), 32'd2);
    checkOutput("after stall bubble", 32'(sv0[0]), 32'd0);
    checkOutput("after stall cnt", 32'(cnt0), 32'd1);
    checkOutput("deep load-use stall 2", 32'(stall2), 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    checkOutput("deep stall end", 32'(stall2), 32'd0);
    checkOutput("deep stall cnt", 32'(cnt2), 32'd2);

    // Load-use with flush in the same cycle
    doReset();
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    #3;
    checkOutput("flush stall", 32'(stall0), 32'd0);
    idle();
    #3;
    checkOutput("flush bubble", 32'(sv0[0]), 32'd0);
    checkOutput("flush cnt", 32'(cnt0), 32'd0);

    // $0 written everywhere, then read
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    checkOutput("r0 fwda", 32'(fwda0), 32'd0);
    checkOutput("r0 fwdb", 32'(fwdb0), 32'd0);
    checkOutput("r0 stall", 32'(stall0), 32'd0);
    checkOutput("r0 dfwdB", dB0, qb);

    // Five load-use stalls: CNT_W=2 saturates at 3
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    end
    #3;
    checkOutput("saturated cnt", 32'(cnt1), 32'd3);
    checkOutput("unsaturated cnt", 32'(cnt0), 32'd5);

    // Reset pulse in the middle of a stall cycle
    doReset();
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    checkOutput("pre-reset stall", 32'(stall0), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("mid-reset stall", 32'(stall0), 32'd0);
    checkOutput("mid-reset deep stall", 32'(stall2), 32'd0);
    checkOutput("mid-reset stage_valid", 32'(sv2), 32'd0);
    checkOutput("mid-reset cnt", 32'(cnt0), 32'd0);
    modelReset();
    #1;
    resetn = 1'b1;

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(99) >= 2) ? 1'b1 : 1'b0,
                    ($urandom_range(99) < 85) ? 1'b1 : 1'b0,
                    5'($urandom_range(3)), 5'($urandom_range(3)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(99) < 35) ? 1'b1 : 1'b0,
                    5'($urandom_range(3)),
                    ($urandom_range(99) < 10) ? 1'b1 : 1'b0);
    end

    idle();
    @(negedge clock);
    #1;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
